// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: state encoding, opcodes, IR field positions.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned WORD_W = 32;

  // IR field bit positions
  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 27;
  localparam int unsigned RaMsb  = 26;
  localparam int unsigned RaLsb  = 23;
  localparam int unsigned RbMsb  = 22;
  localparam int unsigned RbLsb  = 19;
  localparam int unsigned RcMsb  = 18;
  localparam int unsigned RcLsb  = 15;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StT0   = 3'd1,
    StT1   = 3'd2,
    StT2   = 3'd3,
    StT3   = 3'd4,
    StT4   = 3'd5,
    StT5   = 3'd6,
    StHalt = 3'd7
  } state_e;

  localparam logic [OPC_W-1:0] OpcAdd  = 5'b00011;
  localparam logic [OPC_W-1:0] OpcSub  = 5'b00100;
  localparam logic [OPC_W-1:0] OpcAnd  = 5'b00101;
  localparam logic [OPC_W-1:0] OpcOr   = 5'b00110;
  localparam logic [OPC_W-1:0] OpcShr  = 5'b00111;
  localparam logic [OPC_W-1:0] OpcShl  = 5'b01000;
  localparam logic [OPC_W-1:0] OpcNop  = 5'b11010;
  localparam logic [OPC_W-1:0] OpcHalt = 5'b11011;

  function automatic logic [OPC_W-1:0] get_opc(input logic [WORD_W-1:0] word);
    return word[OpcMsb:OpcLsb];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; exactly one of the four outputs is high for any opcode.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output logic             is_rtype,
  output logic             is_nop,
  output logic             is_halt,
  output logic             is_illegal
);

  always_comb begin
    is_rtype = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    unique case (opc)
      OpcAdd, OpcSub, OpcAnd, OpcOr, OpcShr, OpcShl: is_rtype = 1'b1;
      OpcNop:  is_nop  = 1'b1;
      OpcHalt: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_illegal = ~(is_rtype | is_nop | is_halt);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control FSM: fetch (T0-T2) with memory-ready wait, then R-format execute (T3-T5).
module control_sequencer #(
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] ir,
  input  logic              mem_ready,
  input  logic              stop,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic [OPC_W-1:0]  alu_op,
  output logic              instr_done,
  output logic              run,
  output logic              illegal_op
);

  import cpu_ctrl_pkg::*;

  state_e            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic [OPC_W-1:0]  opc;
  logic              is_rtype, is_nop, is_halt, is_illegal;
  logic              unused_ir;

  assign opc       = ir[OpcMsb:OpcLsb];
  // Register fields are consumed by the datapath's select-and-encode, not here.
  assign unused_ir = ^ir[OpcLsb-1:0];

  ctrl_decode u_decode (
    .opc        (opc),
    .is_rtype   (is_rtype),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StIdle: if (!stop) state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   if (mem_ready) state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (is_rtype) begin
          state_d = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else if (is_nop || is_illegal) begin
          state_d   = stop ? StIdle : StT0;
          illegal_d = illegal_q | is_illegal;
        end
      end
      StT4:   state_d = StT5;
      StT5:   state_d = stop ? StIdle : StT0;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    run        = 1'b0;
    unique case (state_q)
      StT0: begin
        run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT2: begin
        run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        run = 1'b1;
        if (is_rtype) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        run    = 1'b1;
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = opc;
      end
      StT5: begin
        run        = 1'b1;
        Zlowout    = 1'b1;
        Gra        = 1'b1;
        Rin        = 1'b1;
        instr_done = 1'b1;
      end
      StIdle, StHalt: ;
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath's control strobes.
- Sequences instruction fetch (T0-T2), then the R-format ALU execute (T3-T5) from the IR contents.
- Sits beside Datapath and replaces hand-driven control with a clocked FSM.
- Adds a memory-ready wait in T1, plus stop, halt and illegal-opcode handling.

Parameters:
- OPC_W, 5, opcode width (IR[31:27]); also the width of alu_op.
- WORD_W, 32, instruction register width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- ir  in  WORD_W  IR contents from Datapath. Fields: opc=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- mem_ready  in  1  memory has Mdatain valid this cycle.
- stop  in  1  request to park in IDLE at the next instruction boundary.
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes.
- Gra, Grb, Grc  out  1 each  register-field select for select-and-encode.
- Rin, Rout  out  1 each  general-register write/read enable through the selected field.
- alu_op  out  OPC_W  ALU function; equals opc when Zin is asserted in T4, else 0.
- instr_done  out  1  one-cycle pulse in T5.
- run  out  1  high in T0-T5.
- illegal_op  out  1  sticky flag.

Behaviour:
- Reset is asynchronous, active-high: reset=1 forces state IDLE immediately, clears illegal_op, and drives every output to 0 in the same instant. This also applies mid-instruction; no partial completion.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- Outputs are decoded from state, plus ir in T3 and T4 only. Each output is held for the full cycle; anything not listed for a state is 0.
- IDLE: no outputs. Go to T0 when stop=0, else stay.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - mem_ready=0: stay in T1 with the same outputs. Rewriting PC from unchanged Z is harmless.
  - mem_ready=1: go to T2; MDR captures on this edge.
- T2: MDRout, IRin. Go to T3; IR is valid from T3 onward.
- T3: decode opc.
  - R-type (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000): Grb, Rout, Yin. Go to T4.
  - nop 11010: no outputs. Go to T0, or to IDLE if stop=1.
  - halt 11011: no outputs. Go to HALT.
  - Any other opcode: no outputs; set illegal_op on this edge. Go to T0, or IDLE if stop=1.
- T4: Grc, Rout, Zin, alu_op=opc. Go to T5.
- T5: Zlowout, Gra, Rin, instr_done. Go to T0, or IDLE if stop=1.
- HALT: run=0, all outputs 0. Exit only by reset; stop is ignored.
- stop is sampled only on exit from IDLE, T3 (nop/illegal paths) and T5. Asserting it mid-instruction never truncates that instruction.
- illegal_op is cleared only by reset. A second illegal opcode leaves it set.
- Exactly one of Gra/Grb/Grc is high in any cycle where Rin or Rout is high.
- Rin and Rout are never high together.
- Latency: an R-type instruction takes 6 cycles plus the number of T1 wait cycles.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding (8 states, 3 bits);
  - the opcode constants listed above;
  - the IR field bit positions;
  - OPC_W.
- One sub-module, ctrl_decode: purely combinational classifier of opc into is_rtype, is_nop, is_halt, is_illegal. It is reused by the datapath ALU select later.

Test Plan:
- Reset, then stop=0, mem_ready=1, ir=0x28918000 (and R1,R2,R3) -> states T0..T5 in 6 cycles.
  - T3: Grb=1, Rout=1, Yin=1.
  - T4: Grc=1, Rout=1, Zin=1, alu_op=5'b00101.
  - T5: Gra=1, Rin=1, instr_done=1.
  - Then T0 again.
- mem_ready=0 for 3 cycles in T1 -> T1 held 4 cycles with Read=1 and MDRin=1 throughout; T2 follows the first cycle with mem_ready=1.
- ir opc=11011 -> HALT after T3; run=0 and all outputs 0 for 20+ cycles; an async reset pulse returns to IDLE.
- ir opc=11111 -> illegal_op=1 from the T3 edge onward; fetch restarts at T0; illegal_op stays 1 through a following valid add (opc 00011).
- stop=1 raised during T4 -> instruction completes (instr_done pulse in T5), then IDLE. Dropping stop -> T0 on the next edge.
- reset asserted mid-T4 (between edges) -> all outputs 0 and run=0 immediately, without waiting for a clock edge; IDLE after release.
